// File: rtl/writeback_stage.sv
// Writeback stage: picks the result source, applies load extension, queues up
// to two results and drains them into the register file with valid/ready.
// Also answers bypass lookups from pending entries and counts retirements.
module writeback_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int MEM_SRC = 1,
    parameter int ADDR_W  = 5,
    localparam int SEL_W  = $clog2(NUM_SRC),
    localparam int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_SRC*XLEN-1:0] in_src_data,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic                    in_rd_we,
    input  logic [2:0]              in_ld_funct3,
    input  logic [OFF_W-1:0]        in_ld_off,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    input  logic                    rf_ready,
    input  logic [ADDR_W-1:0]       fwd_rd,
    output logic                    fwd_hit,
    output logic [XLEN-1:0]         fwd_data,
    output logic [63:0]             instret,
    output logic                    sel_err
);

    localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] MEM_SEL   = SEL_W'(MEM_SRC);
    // Masks that drop the low offset bits for half/word lanes; misaligned
    // offsets simply fall back to the enclosing aligned lane.
    localparam logic [OFF_W-1:0] HALF_MASK = ~(OFF_W'(1));
    localparam logic [OFF_W-1:0] WORD_MASK = ~(OFF_W'(3));

    // Two-entry circular queue
    logic [ADDR_W-1:0] ent_rd_q   [2];
    logic              ent_we_q   [2];
    logic [XLEN-1:0]   ent_data_q [2];
    logic              head_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Last popped entry, shown on rf_* while the queue is empty
    logic [ADDR_W-1:0] last_rd_q;
    logic [XLEN-1:0]   last_data_q;

    logic [63:0]       instret_q;
    logic              sel_err_q;

    logic [XLEN-1:0]   src [NUM_SRC];
    logic [XLEN-1:0]   mem_src;
    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   res_data;
    logic              sel_valid;
    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;

    logic              push;
    logic              pop;
    logic              tail;
    logic              young;
    logic              young_hit;
    logic              old_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src[gi] = in_src_data[gi*XLEN +: XLEN];
        end
    endgenerate

    assign mem_src = src[MEM_SRC];

    // Source mux; out-of-range selects yield zero
    always_comb begin
        sel_valid = ({1'b0, in_sel} < NUM_SRC_W);
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_data = src[i];
            end
        end
    end

    assign off_h  = in_ld_off & HALF_MASK;
    assign off_w  = in_ld_off & WORD_MASK;
    assign lane_b = mem_src[{in_ld_off, 3'b000} +: 8];
    assign lane_h = mem_src[{off_h, 3'b000} +: 16];
    assign lane_w = mem_src[{off_w, 3'b000} +: 32];

    // Load sign/zero extension of the data-memory source
    always_comb begin
        ld_data = mem_src;
        case (in_ld_funct3)
            3'b000: begin
                ld_data      = {XLEN{lane_b[7]}};
                ld_data[7:0] = lane_b;
            end
            3'b001: begin
                ld_data       = {XLEN{lane_h[15]}};
                ld_data[15:0] = lane_h;
            end
            3'b100: begin
                ld_data      = '0;
                ld_data[7:0] = lane_b;
            end
            3'b101: begin
                ld_data       = '0;
                ld_data[15:0] = lane_h;
            end
            3'b010: begin
                if (XLEN == 64) begin
                    ld_data       = {XLEN{lane_w[31]}};
                    ld_data[31:0] = lane_w;
                end
            end
            3'b110: begin
                if (XLEN == 64) begin
                    ld_data       = '0;
                    ld_data[31:0] = lane_w;
                end
            end
            default: ld_data = mem_src;
        endcase
    end

    assign res_data = (sel_valid && (in_sel == MEM_SEL)) ? ld_data : sel_data;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = (count_q != 2'd0) & rf_ready;
    // Next free slot: head when empty, the other slot when one is held
    assign tail     = head_q ^ count_q[0];

    // Occupancy bookkeeping for simultaneous push/pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ent_rd_q[i]   <= '0;
                ent_we_q[i]   <= 1'b0;
                ent_data_q[i] <= '0;
            end
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                ent_rd_q[tail]   <= in_rd;
                ent_we_q[tail]   <= in_rd_we;
                ent_data_q[tail] <= res_data;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
        end
    end

    // Retirement counter, held-output copy and sticky select error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_q   <= '0;
            last_data_q <= '0;
            instret_q   <= 64'd0;
            sel_err_q   <= 1'b0;
        end else begin
            if (pop) begin
                last_rd_q   <= ent_rd_q[head_q];
                last_data_q <= ent_data_q[head_q];
                instret_q   <= instret_q + 64'd1;
            end
            if (push && !sel_valid) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign rf_we    = (count_q != 2'd0) & ent_we_q[head_q] & (ent_rd_q[head_q] != '0);
    assign rf_waddr = (count_q != 2'd0) ? ent_rd_q[head_q]   : last_rd_q;
    assign rf_wdata = (count_q != 2'd0) ? ent_data_q[head_q] : last_data_q;
    assign instret  = instret_q;
    assign sel_err  = sel_err_q;

    // Youngest pending entry is the tail-side slot when two are held
    assign young     = head_q ^ (count_q == 2'd2);
    assign young_hit = (count_q != 2'd0) & ent_we_q[young] & (ent_rd_q[young] == fwd_rd)
                       & (fwd_rd != '0);
    assign old_hit   = (count_q == 2'd2) & ent_we_q[head_q] & (ent_rd_q[head_q] == fwd_rd)
                       & (fwd_rd != '0);

    // Bypass lookup, youngest match first
    always_comb begin
        fwd_hit  = young_hit | old_hit;
        fwd_data = '0;
        if (young_hit) begin
            fwd_data = ent_data_q[young];
        end else if (old_hit) begin
            fwd_data = ent_data_q[head_q];
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a vector table for source select and
// load extension, plus hand-written sequences for backpressure, bypass,
// x0/no-write retirement, mid-stream reset and the sticky select error.
module tb_writeback_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // Main instance: default parameters (XLEN=32, NUM_SRC=4)
    logic        in_valid, in_ready;
    logic [1:0]  in_sel;
    logic [127:0] in_src_data;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_ld_off;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ready;
    logic [4:0]  fwd_rd;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [63:0] instret;
    logic        sel_err;

    // Second instance with three sources to reach an invalid select
    logic        t3_in_valid, t3_in_ready;
    logic [1:0]  t3_in_sel;
    logic [95:0] t3_in_src_data;
    logic [4:0]  t3_in_rd;
    logic        t3_in_rd_we;
    logic [2:0]  t3_in_ld_funct3;
    logic [1:0]  t3_in_ld_off;
    logic        t3_rf_we;
    logic [4:0]  t3_rf_waddr;
    logic [31:0] t3_rf_wdata;
    logic        t3_rf_ready;
    logic [4:0]  t3_fwd_rd;
    logic        t3_fwd_hit;
    logic [31:0] t3_fwd_data;
    logic [63:0] t3_instret;
    logic        t3_sel_err;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_src_data(in_src_data), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .instret(instret), .sel_err(sel_err)
    );

    writeback_stage #(.NUM_SRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t3_in_valid), .in_ready(t3_in_ready), .in_sel(t3_in_sel),
        .in_src_data(t3_in_src_data), .in_rd(t3_in_rd), .in_rd_we(t3_in_rd_we),
        .in_ld_funct3(t3_in_ld_funct3), .in_ld_off(t3_in_ld_off),
        .rf_we(t3_rf_we), .rf_waddr(t3_rf_waddr), .rf_wdata(t3_rf_wdata),
        .rf_ready(t3_rf_ready),
        .fwd_rd(t3_fwd_rd), .fwd_hit(t3_fwd_hit), .fwd_data(t3_fwd_data),
        .instret(t3_instret), .sel_err(t3_sel_err)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [15];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_instret = 64'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selected source carries d; the others get a distinct filler pattern
    task automatic load_srcs(input logic [1:0] sel, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            in_src_data[i*32 +: 32] = (i == int'(sel)) ? d : (32'hA5A5_0000 | 32'(i));
        end
    endtask

    task automatic push_one(input logic [1:0] sel, input logic [31:0] d,
                            input logic [4:0] rd, input logic we);
        in_valid     = 1'b1;
        in_sel       = sel;
        load_srcs(sel, d);
        in_rd        = rd;
        in_rd_we     = we;
        in_ld_funct3 = 3'b000;
        in_ld_off    = 2'd0;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h0000_1234, 3'b000, 2'd0, 5'd5,  32'h0000_1234};
        vecs[1]  = '{2'd1, 32'h80FF_7F01, 3'b000, 2'd3, 5'd10, 32'hFFFF_FF80};
        vecs[2]  = '{2'd1, 32'h80FF_7F01, 3'b100, 2'd1, 5'd11, 32'h0000_007F};
        vecs[3]  = '{2'd1, 32'h80FF_7F01, 3'b001, 2'd2, 5'd12, 32'hFFFF_80FF};
        vecs[4]  = '{2'd1, 32'h80FF_7F01, 3'b101, 2'd0, 5'd13, 32'h0000_7F01};
        vecs[5]  = '{2'd1, 32'h80FF_7F01, 3'b010, 2'd0, 5'd14, 32'h80FF_7F01};
        vecs[6]  = '{2'd1, 32'h80FF_7F01, 3'b000, 2'd0, 5'd15, 32'h0000_0001};
        vecs[7]  = '{2'd1, 32'h80FF_7F01, 3'b001, 2'd3, 5'd16, 32'hFFFF_80FF};
        vecs[8]  = '{2'd1, 32'h80FF_7F01, 3'b100, 2'd2, 5'd17, 32'h0000_00FF};
        vecs[9]  = '{2'd2, 32'h0040_0010, 3'b000, 2'd3, 5'd3,  32'h0040_0010};
        vecs[10] = '{2'd3, 32'hDEAD_BEEF, 3'b001, 2'd1, 5'd31, 32'hDEAD_BEEF};
        vecs[11] = '{2'd0, 32'h80FF_7F01, 3'b000, 2'd3, 5'd1,  32'h80FF_7F01};
        vecs[12] = '{2'd1, 32'h80FF_7F01, 3'b101, 2'd3, 5'd18, 32'h0000_80FF};
        vecs[13] = '{2'd1, 32'h80FF_7F01, 3'b111, 2'd2, 5'd19, 32'h80FF_7F01};
        vecs[14] = '{2'd1, 32'h80FF_7F01, 3'b110, 2'd1, 5'd20, 32'h80FF_7F01};

        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = '0; in_src_data = '0; in_rd = '0; in_rd_we = 1'b0;
        in_ld_funct3 = '0; in_ld_off = '0; rf_ready = 1'b0; fwd_rd = '0;
        t3_in_valid = 1'b0; t3_in_sel = '0; t3_in_src_data = '0; t3_in_rd = '0;
        t3_in_rd_we = 1'b0; t3_in_ld_funct3 = '0; t3_in_ld_off = '0;
        t3_rf_ready = 1'b0; t3_fwd_rd = '0;

        // Reset state
        #3;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_instret", instret, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_in_ready", in_ready, 1);
        #7 rst_n = 1'b1;
        tick();

        // Table: one instruction per vector, drained immediately
        for (int k = 0; k < 15; k++) begin
            rf_ready     = 1'b1;
            in_valid     = 1'b1;
            in_sel       = vecs[k].sel;
            load_srcs(vecs[k].sel, vecs[k].data);
            in_ld_funct3 = vecs[k].f3;
            in_ld_off    = vecs[k].off;
            in_rd        = vecs[k].rd;
            in_rd_we     = 1'b1;
            #2 chk("vec_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            #2;
            chk("vec_rf_we", rf_we, 1);
            chk("vec_waddr", rf_waddr, vecs[k].rd);
            chk("vec_wdata", rf_wdata, vecs[k].exp);
            $display("vec %0d: sel=%0d f3=%b off=%0d rd=%0d wdata=0x%08h",
                     k, vecs[k].sel, vecs[k].f3, vecs[k].off, rf_waddr, rf_wdata);
            tick();
            exp_instret++;
            #2;
            chk("vec_instret", instret, exp_instret);
            chk("vec_empty_we", rf_we, 0);
            chk("vec_hold_waddr", rf_waddr, vecs[k].rd);
            chk("vec_hold_wdata", rf_wdata, vecs[k].exp);
        end

        // Backpressure: three pushes with the register file stalled
        rf_ready = 1'b0;
        push_one(2'd0, 32'h0000_AAA1, 5'd1, 1'b1);
        #2 chk("bp_ready0", in_ready, 1);
        tick();
        push_one(2'd0, 32'h0000_BBB2, 5'd2, 1'b1);
        #2;
        chk("bp_head_we", rf_we, 1);
        chk("bp_head_waddr", rf_waddr, 1);
        chk("bp_head_wdata", rf_wdata, 32'h0000_AAA1);
        chk("bp_ready1", in_ready, 1);
        tick();
        push_one(2'd0, 32'h0000_CCC3, 5'd3, 1'b1);
        #2 chk("bp_full_ready", in_ready, 0);
        tick();
        #2;
        chk("bp_still_full", in_ready, 0);
        chk("bp_hold_head", rf_waddr, 1);
        rf_ready = 1'b1;
        tick();
        exp_instret++;
        #2;
        chk("bp_second_waddr", rf_waddr, 2);
        chk("bp_second_wdata", rf_wdata, 32'h0000_BBB2);
        chk("bp_ready_again", in_ready, 1);
        $display("bp: popped rd=1, head rd=%0d", rf_waddr);
        tick();
        exp_instret++;
        in_valid = 1'b0;
        #2;
        chk("bp_third_we", rf_we, 1);
        chk("bp_third_waddr", rf_waddr, 3);
        chk("bp_third_wdata", rf_wdata, 32'h0000_CCC3);
        $display("bp: popped rd=2, head rd=%0d", rf_waddr);
        tick();
        exp_instret++;
        #2;
        chk("bp_empty_we", rf_we, 0);
        chk("bp_hold_waddr", rf_waddr, 3);
        chk("bp_hold_wdata", rf_wdata, 32'h0000_CCC3);
        chk("bp_instret", instret, exp_instret);
        $display("bp: popped rd=3, instret=%0d", instret);

        // Bypass: two writes to x7, youngest wins
        rf_ready = 1'b0;
        fwd_rd   = 5'd7;
        push_one(2'd0, 32'h0000_000A, 5'd7, 1'b1);
        #2 chk("fwd_incycle_hidden", fwd_hit, 0);
        tick();
        push_one(2'd0, 32'h0000_000B, 5'd7, 1'b1);
        #2;
        chk("fwd_one_hit", fwd_hit, 1);
        chk("fwd_one_data", fwd_data, 32'h0000_000A);
        tick();
        in_valid = 1'b0;
        #2;
        chk("fwd_two_hit", fwd_hit, 1);
        chk("fwd_young_data", fwd_data, 32'h0000_000B);
        fwd_rd = 5'd8;
        #1 chk("fwd_other_rd", fwd_hit, 0);
        fwd_rd = 5'd7;
        $display("fwd: two pending x7 entries, data=0x%08h", fwd_data);
        rf_ready = 1'b1;
        tick();
        exp_instret++;
        #2;
        chk("fwd_after_pop_hit", fwd_hit, 1);
        chk("fwd_after_pop_data", fwd_data, 32'h0000_000B);
        tick();
        exp_instret++;
        #2 chk("fwd_drained", fwd_hit, 0);

        // x0 write: suppressed, not forwarded, still retires
        rf_ready = 1'b0;
        fwd_rd   = 5'd0;
        push_one(2'd0, 32'h0000_0055, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        #2;
        chk("x0_fwd_hit", fwd_hit, 0);
        chk("x0_rf_we", rf_we, 0);
        rf_ready = 1'b1;
        tick();
        exp_instret++;
        #2 chk("x0_instret", instret, exp_instret);
        $display("x0: retired without write, instret=%0d", instret);

        // rd_we=0: no write, no bypass, still retires
        rf_ready = 1'b0;
        fwd_rd   = 5'd9;
        push_one(2'd0, 32'h0000_0099, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        chk("nowe_fwd_hit", fwd_hit, 0);
        chk("nowe_rf_we", rf_we, 0);
        chk("nowe_waddr", rf_waddr, 9);
        rf_ready = 1'b1;
        tick();
        exp_instret++;
        #2 chk("nowe_instret", instret, exp_instret);
        $display("nowe: retired rd=9 without write, instret=%0d", instret);

        // Reset with two entries queued
        rf_ready = 1'b0;
        fwd_rd   = 5'd4;
        push_one(2'd0, 32'h0000_0044, 5'd4, 1'b1);
        tick();
        push_one(2'd0, 32'h0000_0045, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        #2;
        chk("mr_full", in_ready, 0);
        chk("mr_fwd_before", fwd_hit, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_rf_we", rf_we, 0);
        chk("mr_waddr", rf_waddr, 0);
        chk("mr_wdata", rf_wdata, 0);
        chk("mr_fwd_hit", fwd_hit, 0);
        chk("mr_instret", instret, 0);
        chk("mr_in_ready", in_ready, 1);
        exp_instret = 64'd0;
        tick();
        rst_n    = 1'b1;
        rf_ready = 1'b1;
        tick();
        #2;
        chk("mr_no_write", rf_we, 0);
        chk("mr_no_retire", instret, 0);
        chk("main_sel_err", sel_err, 0);
        $display("mid-reset: queue discarded, instret=%0d", instret);

        // Three-source instance: invalid select gives zero data and sticky error
        for (int i = 0; i < 3; i++) begin
            t3_in_src_data[i*32 +: 32] = 32'h1111_1111 * (i + 1);
        end
        chk("t3_sel_err_init", t3_sel_err, 0);
        t3_rf_ready = 1'b0;
        t3_in_valid = 1'b1;
        t3_in_sel   = 2'd3;
        t3_in_rd    = 5'd6;
        t3_in_rd_we = 1'b1;
        tick();
        t3_in_valid = 1'b0;
        #2;
        chk("t3_bad_we", t3_rf_we, 1);
        chk("t3_bad_wdata", t3_rf_wdata, 0);
        chk("t3_sel_err_set", t3_sel_err, 1);
        $display("t3: sel=3 rd=6 wdata=0x%08h sel_err=%0d", t3_rf_wdata, t3_sel_err);
        t3_rf_ready = 1'b1;
        tick();
        #2 chk("t3_instret", t3_instret, 1);
        t3_in_valid = 1'b1;
        t3_in_sel   = 2'd2;
        tick();
        t3_in_valid = 1'b0;
        #2;
        chk("t3_good_wdata", t3_rf_wdata, 32'h3333_3333);
        chk("t3_sel_err_sticky", t3_sel_err, 1);
        tick();
        tick();
        #2 chk("t3_sel_err_idle", t3_sel_err, 1);
        rst_n = 1'b0;
        #1 chk("t3_sel_err_reset", t3_sel_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        #2 chk("t3_sel_err_after", t3_sel_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
